// File: rtl/drac_pkg.sv
// Shared types and constants for the execute-to-writeback path.
package drac_pkg;

    typedef enum logic {
        WB_SRC_ALU = 1'b0,
        WB_SRC_MD  = 1'b1
    } wb_src_t;

    localparam int unsigned EXE_WB_DATA_W   = 64;
    localparam int unsigned EXE_WB_REG_W    = 5;
    localparam int unsigned EXE_WB_MD_DEPTH = 2;

    typedef struct packed {
        logic [EXE_WB_REG_W-1:0]  rd;
        logic                     we;
        logic [EXE_WB_DATA_W-1:0] data;
    } md_wb_entry_t;

endpackage

// File: rtl/wb_md_fifo.sv
// In-order synchronous FIFO buffering mul/div results until a writeback slot is free.
module wb_md_fifo #(
    parameter int unsigned Width = 70,
    parameter int unsigned Depth = 2,
    localparam int unsigned PtrW = $clog2(Depth),
    localparam int unsigned CntW = PtrW + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] data_i,
    output logic [Width-1:0] data_o,
    output logic [CntW-1:0]  count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PtrW-1:0]  wptr_q, wptr_d;
    logic [PtrW-1:0]  rptr_q, rptr_d;
    logic [CntW-1:0]  count_q, count_d;

    always_comb begin
        mem_d   = mem_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) begin
                mem_d[wptr_q] = data_i;
                wptr_d        = wptr_q + PtrW'(1);
            end
            if (pop_i) begin
                rptr_d = rptr_q + PtrW'(1);
            end
            count_d = count_q + CntW'(push_i) - CntW'(pop_i);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    assign data_o  = mem_q[rptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/exe_wb_arbiter.sv
// Merges the fixed-latency ALU stream and the buffered mul/div stream onto one
// registered writeback port; ALU results always take the slot.
module exe_wb_arbiter
    import drac_pkg::*;
#(
    parameter int unsigned DATA_W = EXE_WB_DATA_W,
    parameter int unsigned REG_W  = EXE_WB_REG_W,
    parameter int unsigned DEPTH  = EXE_WB_MD_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              arith_valid_i,
    input  logic [REG_W-1:0]  arith_rd_i,
    input  logic              arith_we_i,
    input  logic              arith_xcpt_i,
    input  logic [DATA_W-1:0] arith_data_i,
    input  logic              md_valid_i,
    output logic              md_ready_o,
    input  logic [REG_W-1:0]  md_rd_i,
    input  logic              md_we_i,
    input  logic [DATA_W-1:0] md_data_i,
    output logic              wb_valid_o,
    output logic [REG_W-1:0]  wb_rd_o,
    output logic              wb_we_o,
    output logic              wb_xcpt_o,
    output logic              wb_src_o,
    output logic [DATA_W-1:0] wb_data_o,
    output logic [31:0]       wb_count_o
);

    localparam int unsigned EntryW = REG_W + 1 + DATA_W;
    localparam int unsigned CntW   = $clog2(DEPTH) + 1;

    logic [EntryW-1:0] fifo_wdata, fifo_rdata;
    logic [CntW-1:0]   fifo_count;
    logic              fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic              md_accept;

    logic              wb_valid_q, wb_valid_d;
    logic [REG_W-1:0]  wb_rd_q, wb_rd_d;
    logic              wb_we_q, wb_we_d;
    logic              wb_xcpt_q, wb_xcpt_d;
    wb_src_t           wb_src_q, wb_src_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [31:0]       wb_count_q, wb_count_d;
    logic              sel_we;

    // Ready comes from registered occupancy only, so a same-cycle pop never raises it.
    assign md_ready_o = !rst_i && (fifo_count < CntW'(DEPTH));
    assign md_accept  = md_valid_i && md_ready_o && !flush_i;
    assign fifo_wdata = {md_rd_i, md_we_i, md_data_i};

    always_comb begin
        fifo_push  = 1'b0;
        fifo_pop   = 1'b0;
        wb_valid_d = 1'b0;
        wb_rd_d    = '0;
        sel_we     = 1'b0;
        wb_xcpt_d  = 1'b0;
        wb_src_d   = WB_SRC_ALU;
        wb_data_d  = '0;
        if (!flush_i) begin
            if (arith_valid_i) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = arith_rd_i;
                sel_we     = arith_we_i;
                wb_xcpt_d  = arith_xcpt_i;
                wb_data_d  = arith_data_i;
                fifo_push  = md_accept && !fifo_full;
            end else if (!fifo_empty) begin
                wb_valid_d                    = 1'b1;
                wb_src_d                      = WB_SRC_MD;
                {wb_rd_d, sel_we, wb_data_d} = fifo_rdata;
                fifo_pop                      = 1'b1;
                fifo_push                     = md_accept && !fifo_full;
            end else if (md_accept) begin
                wb_valid_d = 1'b1;
                wb_src_d   = WB_SRC_MD;
                wb_rd_d    = md_rd_i;
                sel_we     = md_we_i;
                wb_data_d  = md_data_i;
            end
        end
        wb_we_d    = sel_we && (wb_rd_d != '0) && !wb_xcpt_d;
        wb_count_d = wb_count_q + 32'(wb_valid_d);
    end

    wb_md_fifo #(
        .Width (EntryW),
        .Depth (DEPTH)
    ) u_md_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (flush_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .data_i  (fifo_wdata),
        .data_o  (fifo_rdata),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_we_q    <= 1'b0;
            wb_xcpt_q  <= 1'b0;
            wb_src_q   <= WB_SRC_ALU;
            wb_data_q  <= '0;
            wb_count_q <= '0;
        end else begin
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_we_q    <= wb_we_d;
            wb_xcpt_q  <= wb_xcpt_d;
            wb_src_q   <= wb_src_d;
            wb_data_q  <= wb_data_d;
            wb_count_q <= wb_count_d;
        end
    end

    assign wb_valid_o = wb_valid_q;
    assign wb_rd_o    = wb_rd_q;
    assign wb_we_o    = wb_we_q;
    assign wb_xcpt_o  = wb_xcpt_q;
    assign wb_src_o   = wb_src_q;
    assign wb_data_o  = wb_data_q;
    assign wb_count_o = wb_count_q;

endmodule

// File: tb/tb_exe_wb_arbiter.sv
// Directed bench for exe_wb_arbiter with hand-computed expected writebacks.
module tb_exe_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        flush_i;
    logic        arith_valid_i;
    logic [4:0]  arith_rd_i;
    logic        arith_we_i;
    logic        arith_xcpt_i;
    logic [63:0] arith_data_i;
    logic        md_valid_i;
    logic        md_ready_o;
    logic [4:0]  md_rd_i;
    logic        md_we_i;
    logic [63:0] md_data_i;
    logic        wb_valid_o;
    logic [4:0]  wb_rd_o;
    logic        wb_we_o;
    logic        wb_xcpt_o;
    logic        wb_src_o;
    logic [63:0] wb_data_o;
    logic [31:0] wb_count_o;

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    exe_wb_arbiter dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .flush_i       (flush_i),
        .arith_valid_i (arith_valid_i),
        .arith_rd_i    (arith_rd_i),
        .arith_we_i    (arith_we_i),
        .arith_xcpt_i  (arith_xcpt_i),
        .arith_data_i  (arith_data_i),
        .md_valid_i    (md_valid_i),
        .md_ready_o    (md_ready_o),
        .md_rd_i       (md_rd_i),
        .md_we_i       (md_we_i),
        .md_data_i     (md_data_i),
        .wb_valid_o    (wb_valid_o),
        .wb_rd_o       (wb_rd_o),
        .wb_we_o       (wb_we_o),
        .wb_xcpt_o     (wb_xcpt_o),
        .wb_src_o      (wb_src_o),
        .wb_data_o     (wb_data_o),
        .wb_count_o    (wb_count_o)
    );

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        flush_i       = 1'b0;
        arith_valid_i = 1'b0;
        arith_rd_i    = '0;
        arith_we_i    = 1'b0;
        arith_xcpt_i  = 1'b0;
        arith_data_i  = '0;
        md_valid_i    = 1'b0;
        md_rd_i       = '0;
        md_we_i       = 1'b0;
        md_data_i     = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_i = 1'b1;
        step();
        step();
        checks++; if (md_ready_o !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", md_ready_o); end
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %0b exp 0", wb_valid_o); end
        checks++; if (wb_count_o !== 32'd0) begin errors++; $display("FAIL rst_count got %0d exp 0", wb_count_o); end
        checks++; if ({wb_rd_o, wb_we_o, wb_xcpt_o, wb_src_o, wb_data_o} !== '0) begin errors++; $display("FAIL rst_outputs got rd=%0d we=%0b x=%0b src=%0b data=%0h exp all 0", wb_rd_o, wb_we_o, wb_xcpt_o, wb_src_o, wb_data_o); end
        rst_i = 1'b0;
        #1;
        checks++; if (md_ready_o !== 1'b1) begin errors++; $display("FAIL post_rst_ready got %0b exp 1", md_ready_o); end
    endtask

    task automatic test_alu_only();
        arith_valid_i = 1'b1; arith_rd_i = 5'd5; arith_we_i = 1'b1; arith_data_i = 64'h1234;
        step();
        idle_inputs();
        checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL alu_valid got %0b exp 1", wb_valid_o); end
        checks++; if (wb_src_o !== 1'b0) begin errors++; $display("FAIL alu_src got %0b exp 0", wb_src_o); end
        checks++; if (wb_rd_o !== 5'd5) begin errors++; $display("FAIL alu_rd got %0d exp 5", wb_rd_o); end
        checks++; if (wb_we_o !== 1'b1) begin errors++; $display("FAIL alu_we got %0b exp 1", wb_we_o); end
        checks++; if (wb_data_o !== 64'h1234) begin errors++; $display("FAIL alu_data got %0h exp 1234", wb_data_o); end
        checks++; if (wb_count_o !== 32'd1) begin errors++; $display("FAIL alu_count got %0d exp 1", wb_count_o); end
        step();
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL alu_idle_valid got %0b exp 0", wb_valid_o); end
        checks++; if (wb_count_o !== 32'd1) begin errors++; $display("FAIL alu_idle_count got %0d exp 1", wb_count_o); end
    endtask

    task automatic test_bypass();
        md_valid_i = 1'b1; md_rd_i = 5'd7; md_we_i = 1'b1; md_data_i = 64'hDEAD;
        #1;
        checks++; if (md_ready_o !== 1'b1) begin errors++; $display("FAIL byp_ready got %0b exp 1", md_ready_o); end
        step();
        idle_inputs();
        checks++; if (wb_valid_o !== 1'b1) begin errors++; $display("FAIL byp_valid got %0b exp 1", wb_valid_o); end
        checks++; if (wb_src_o !== 1'b1) begin errors++; $display("FAIL byp_src got %0b exp 1", wb_src_o); end
        checks++; if (wb_data_o !== 64'hDEAD) begin errors++; $display("FAIL byp_data got %0h exp dead", wb_data_o); end
        checks++; if (wb_rd_o !== 5'd7) begin errors++; $display("FAIL byp_rd got %0d exp 7", wb_rd_o); end
        step();
        // A bypassed result must not also have been buffered.
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL byp_no_dup got %0b exp 0", wb_valid_o); end
        checks++; if (wb_count_o !== 32'd2) begin errors++; $display("FAIL byp_count got %0d exp 2", wb_count_o); end
    endtask

    task automatic test_collision();
        arith_valid_i = 1'b1; arith_rd_i = 5'd3; arith_we_i = 1'b1; arith_data_i = 64'hA;
        md_valid_i = 1'b1; md_rd_i = 5'd4; md_we_i = 1'b1; md_data_i = 64'hB;
        step();
        idle_inputs();
        checks++; if (wb_src_o !== 1'b0 || wb_data_o !== 64'hA || wb_rd_o !== 5'd3) begin errors++; $display("FAIL col_alu got src=%0b data=%0h rd=%0d exp src=0 data=a rd=3", wb_src_o, wb_data_o, wb_rd_o); end
        step();
        checks++; if (wb_valid_o !== 1'b1 || wb_src_o !== 1'b1 || wb_data_o !== 64'hB || wb_rd_o !== 5'd4) begin errors++; $display("FAIL col_md got v=%0b src=%0b data=%0h rd=%0d exp v=1 src=1 data=b rd=4", wb_valid_o, wb_src_o, wb_data_o, wb_rd_o); end
        step();
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL col_drain got %0b exp 0", wb_valid_o); end
        checks++; if (wb_count_o !== 32'd4) begin errors++; $display("FAIL col_count got %0d exp 4", wb_count_o); end
    endtask

    task automatic test_fill_to_full();
        arith_valid_i = 1'b1; arith_rd_i = 5'd1; arith_we_i = 1'b1; arith_data_i = 64'h101;
        md_valid_i = 1'b1; md_rd_i = 5'd10; md_we_i = 1'b1; md_data_i = 64'h11;
        step();
        checks++; if (wb_data_o !== 64'h101 || wb_src_o !== 1'b0) begin errors++; $display("FAIL fill_alu got data=%0h src=%0b exp 101 src=0", wb_data_o, wb_src_o); end
        md_rd_i = 5'd11; md_data_i = 64'h22; arith_data_i = 64'h102;
        step();
        checks++; if (md_ready_o !== 1'b0) begin errors++; $display("FAIL fill_full_ready got %0b exp 0", md_ready_o); end
        md_rd_i = 5'd12; md_data_i = 64'h33; arith_data_i = 64'h103;
        step();
        checks++; if (md_ready_o !== 1'b0) begin errors++; $display("FAIL fill_held_ready got %0b exp 0", md_ready_o); end
        checks++; if (wb_data_o !== 64'h103 || wb_src_o !== 1'b0) begin errors++; $display("FAIL fill_alu3 got data=%0h src=%0b exp 103 src=0", wb_data_o, wb_src_o); end
        arith_valid_i = 1'b0;
        step();
        checks++; if (wb_src_o !== 1'b1 || wb_data_o !== 64'h11 || wb_rd_o !== 5'd10) begin errors++; $display("FAIL fill_pop1 got src=%0b data=%0h rd=%0d exp src=1 data=11 rd=10", wb_src_o, wb_data_o, wb_rd_o); end
        checks++; if (md_ready_o !== 1'b1) begin errors++; $display("FAIL fill_ready_back got %0b exp 1", md_ready_o); end
        step();
        md_valid_i = 1'b0;
        checks++; if (wb_src_o !== 1'b1 || wb_data_o !== 64'h22) begin errors++; $display("FAIL fill_pop2 got src=%0b data=%0h exp src=1 data=22", wb_src_o, wb_data_o); end
        step();
        checks++; if (wb_valid_o !== 1'b1 || wb_data_o !== 64'h33 || wb_rd_o !== 5'd12) begin errors++; $display("FAIL fill_pop3 got v=%0b data=%0h rd=%0d exp v=1 data=33 rd=12", wb_valid_o, wb_data_o, wb_rd_o); end
        step();
        idle_inputs();
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL fill_drain got %0b exp 0", wb_valid_o); end
        checks++; if (wb_count_o !== 32'd10) begin errors++; $display("FAIL fill_count got %0d exp 10", wb_count_o); end
    endtask

    task automatic test_flush();
        arith_valid_i = 1'b1; arith_rd_i = 5'd2; arith_we_i = 1'b1; arith_data_i = 64'h77;
        md_valid_i = 1'b1; md_rd_i = 5'd13; md_we_i = 1'b1; md_data_i = 64'h55;
        step();
        md_data_i = 64'h66;
        step();
        flush_i = 1'b1;
        step();
        idle_inputs();
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b exp 0", wb_valid_o); end
        checks++; if (md_ready_o !== 1'b1) begin errors++; $display("FAIL flush_ready got %0b exp 1", md_ready_o); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_stale_%0d got %0b exp 0", i, wb_valid_o); end
        end
        checks++; if (wb_count_o !== 32'd12) begin errors++; $display("FAIL flush_count got %0d exp 12", wb_count_o); end
        // A flush with an empty FIFO must also drop a same-cycle mul/div result.
        flush_i = 1'b1; md_valid_i = 1'b1; md_rd_i = 5'd14; md_we_i = 1'b1; md_data_i = 64'h99;
        step();
        idle_inputs();
        step();
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL flush_bypass_drop got %0b exp 0", wb_valid_o); end
    endtask

    task automatic test_write_suppress();
        arith_valid_i = 1'b1; arith_rd_i = 5'd0; arith_we_i = 1'b1; arith_data_i = 64'h5;
        step();
        checks++; if (wb_valid_o !== 1'b1 || wb_we_o !== 1'b0) begin errors++; $display("FAIL sup_rd0 got v=%0b we=%0b exp v=1 we=0", wb_valid_o, wb_we_o); end
        arith_rd_i = 5'd9; arith_xcpt_i = 1'b1;
        step();
        checks++; if (wb_xcpt_o !== 1'b1 || wb_we_o !== 1'b0 || wb_rd_o !== 5'd9) begin errors++; $display("FAIL sup_xcpt got x=%0b we=%0b rd=%0d exp x=1 we=0 rd=9", wb_xcpt_o, wb_we_o, wb_rd_o); end
        // Exception flag belongs to the ALU source only.
        arith_valid_i = 1'b0; md_valid_i = 1'b1; md_rd_i = 5'd9; md_we_i = 1'b1; md_data_i = 64'h8;
        step();
        checks++; if (wb_xcpt_o !== 1'b0 || wb_we_o !== 1'b1 || wb_src_o !== 1'b1) begin errors++; $display("FAIL sup_md_xcpt got x=%0b we=%0b src=%0b exp x=0 we=1 src=1", wb_xcpt_o, wb_we_o, wb_src_o); end
        arith_xcpt_i = 1'b0; md_rd_i = 5'd0;
        step();
        idle_inputs();
        checks++; if (wb_valid_o !== 1'b1 || wb_we_o !== 1'b0) begin errors++; $display("FAIL sup_md_rd0 got v=%0b we=%0b exp v=1 we=0", wb_valid_o, wb_we_o); end
        step();
        checks++; if (wb_count_o !== 32'd16) begin errors++; $display("FAIL sup_count got %0d exp 16", wb_count_o); end
    endtask

    task automatic test_reset_mid();
        arith_valid_i = 1'b1; arith_rd_i = 5'd6; arith_we_i = 1'b1; arith_data_i = 64'h42;
        md_valid_i = 1'b1; md_rd_i = 5'd8; md_we_i = 1'b1; md_data_i = 64'h43;
        step();
        idle_inputs();
        rst_i = 1'b1;
        step();
        checks++; if (wb_valid_o !== 1'b0 || wb_count_o !== 32'd0 || wb_data_o !== 64'd0) begin errors++; $display("FAIL mid_rst got v=%0b cnt=%0d data=%0h exp 0 0 0", wb_valid_o, wb_count_o, wb_data_o); end
        checks++; if (md_ready_o !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %0b exp 0", md_ready_o); end
        rst_i = 1'b0;
        step();
        checks++; if (wb_valid_o !== 1'b0) begin errors++; $display("FAIL mid_rst_lost got %0b exp 0", wb_valid_o); end
        checks++; if (md_ready_o !== 1'b1) begin errors++; $display("FAIL mid_rst_ready_back got %0b exp 1", md_ready_o); end
    endtask

    initial begin
        test_reset();
        test_alu_only();
        test_bypass();
        test_collision();
        test_fill_to_full();
        test_flush();
        test_write_suppress();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
